// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for a small LoongArch-style datapath (IF/ID/EX/MEM/WB/HALT).
// Latency: 3 cycles for a branch, 4 for ALU ops and st.w, 5 for ld.w, plus memory wait cycles.
// Backpressure: IF and MEM hold until mem_ack arrives; mem_ack outside a request is ignored.
module mc_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] inst,
    input  logic        mem_ack,
    input  logic        alu_zero,
    output logic [2:0]  state,
    output logic [11:0] alu_f,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [1:0]  imm_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        oldpc_we,
    output logic        aluout_we,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } st_t;

    localparam logic [11:0] F_ADD  = 12'h001;
    localparam logic [11:0] F_SUB  = 12'h002;
    localparam logic [11:0] F_PASS = 12'h800;

    st_t         cur;
    st_t         nxt;
    logic        is_3r;
    logic [11:0] f3r;
    logic        is_addi, is_ld, is_st, is_lu12i, is_beq, is_bne, legal;
    logic        unused_inst_bits;

    // The low 15 bits hold register/immediate fields that the datapath consumes directly.
    assign unused_inst_bits = ^inst[14:0];

    assign is_addi  = (inst[31:22] == 10'h00A);
    assign is_ld    = (inst[31:22] == 10'h0A2);
    assign is_st    = (inst[31:22] == 10'h0A6);
    assign is_lu12i = (inst[31:25] == 7'h0A);
    assign is_beq   = (inst[31:26] == 6'h16);
    assign is_bne   = (inst[31:26] == 6'h17);
    assign legal    = is_3r | is_addi | is_ld | is_st | is_lu12i | is_beq | is_bne;
    assign state    = cur;

    // 3R opcode decode to the one-hot ALU function
    always_comb begin
        is_3r = 1'b1;
        f3r   = 12'h000;
        case (inst[31:15])
            17'h00020: f3r = 12'h001;  // add.w
            17'h00022: f3r = 12'h002;  // sub.w
            17'h00024: f3r = 12'h004;  // slt
            17'h00025: f3r = 12'h008;  // sltu
            17'h00029: f3r = 12'h010;  // and
            17'h0002A: f3r = 12'h020;  // or
            17'h00028: f3r = 12'h040;  // nor
            17'h0002B: f3r = 12'h080;  // xor
            17'h0002E: f3r = 12'h100;  // sll.w
            17'h0002F: f3r = 12'h200;  // srl.w
            17'h00030: f3r = 12'h400;  // sra.w
            default:   is_3r = 1'b0;
        endcase
    end

    // State register and sticky illegal-opcode flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur     <= S_IF;
            illegal <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == S_ID && !legal) illegal <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        nxt = cur;
        case (cur)
            S_IF:   if (mem_ack) nxt = S_ID;
            S_ID:   nxt = legal ? S_EX : S_HALT;
            S_EX: begin
                if (is_beq || is_bne)    nxt = S_IF;
                else if (is_ld || is_st) nxt = S_MEM;
                else                     nxt = S_WB;
            end
            S_MEM:  if (mem_ack) nxt = is_ld ? S_WB : S_IF;
            S_WB:   nxt = S_IF;
            S_HALT: nxt = S_HALT;
            default: nxt = S_IF;
        endcase
    end

    // Moore outputs; the IF write strobes and branch pc_we also qualify on ack/zero.
    // Strobes are forced low while reset is held so nothing reaches memory or the regfile.
    always_comb begin
        alu_f     = F_ADD;
        alu_a_sel = 2'd0;
        alu_b_sel = 2'd0;
        imm_sel   = 2'd0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        oldpc_we  = 1'b0;
        aluout_we = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 1'b0;
        case (cur)
            S_IF: begin
                mem_req  = 1'b1;
                ir_we    = mem_ack;
                pc_we    = mem_ack;
                oldpc_we = mem_ack;
            end
            S_ID: begin
                alu_a_sel = 2'd2;
                alu_b_sel = 2'd2;
                imm_sel   = 2'd2;
                aluout_we = 1'b1;
            end
            S_EX: begin
                if (is_3r) begin
                    alu_a_sel = 2'd1;
                    alu_b_sel = 2'd1;
                    alu_f     = f3r;
                    aluout_we = 1'b1;
                end else if (is_addi || is_ld || is_st) begin
                    alu_a_sel = 2'd1;
                    alu_b_sel = 2'd2;
                    aluout_we = 1'b1;
                end else if (is_lu12i) begin
                    alu_b_sel = 2'd2;
                    imm_sel   = 2'd1;
                    alu_f     = F_PASS;
                    aluout_we = 1'b1;
                end else begin
                    alu_a_sel = 2'd1;
                    alu_b_sel = 2'd1;
                    alu_f     = F_SUB;
                    pc_we     = is_beq ? alu_zero : !alu_zero;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_st;
            end
            S_WB: begin
                rf_we  = 1'b1;
                wb_sel = is_ld;
            end
            S_HALT: alu_f = 12'h000;
            default: alu_f = F_ADD;
        endcase
        if (!rstn) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            oldpc_we  = 1'b0;
            aluout_we = 1'b0;
            rf_we     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expectations queued at drive time, checked at negedge.
// Latency: one expectation per clock cycle.
// Backpressure: memory waits modelled by withholding mem_ack for chosen cycles.
module tb_mc_ctrl;

    logic        clk;
    logic        rstn;
    logic [31:0] inst;
    logic        mem_ack;
    logic        alu_zero;
    logic [2:0]  state;
    logic [11:0] alu_f;
    logic [1:0]  alu_a_sel, alu_b_sel, imm_sel;
    logic        mem_req, mem_we, ir_we, pc_we, oldpc_we, aluout_we, rf_we, wb_sel, illegal;

    mc_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .inst      (inst),
        .mem_ack   (mem_ack),
        .alu_zero  (alu_zero),
        .state     (state),
        .alu_f     (alu_f),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .imm_sel   (imm_sel),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .oldpc_we  (oldpc_we),
        .aluout_we (aluout_we),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .illegal   (illegal)
    );

    // Strobe vector order: {mem_req, mem_we, ir_we, pc_we, oldpc_we, aluout_we, rf_we}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] MREQ = 7'b1000000;
    localparam logic [6:0] MWE  = 7'b0100000;
    localparam logic [6:0] IRWE = 7'b0010000;
    localparam logic [6:0] PCWE = 7'b0001000;
    localparam logic [6:0] OPWE = 7'b0000100;
    localparam logic [6:0] AOWE = 7'b0000010;
    localparam logic [6:0] RFWE = 7'b0000001;

    localparam logic [31:0] I_ADD   = 32'h0010_0000;
    localparam logic [31:0] I_SRA   = 32'h0018_0000;
    localparam logic [31:0] I_ADDI  = 32'h0280_0000;
    localparam logic [31:0] I_LD    = 32'h2880_0000;
    localparam logic [31:0] I_ST    = 32'h2980_0000;
    localparam logic [31:0] I_LU12I = 32'h1400_0000;
    localparam logic [31:0] I_BEQ   = 32'h5800_0000;
    localparam logic [31:0] I_BNE   = 32'h5C00_0000;
    localparam logic [31:0] I_BAD   = 32'hFFFF_FFFF;

    typedef struct {
        string       tag;
        logic [29:0] val;
        logic [29:0] msk;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Build an expectation. sel = {a_sel, b_sel, imm_sel} with selm choosing which bits matter.
    // alu_f is compared exactly except in MEM/WB (only one-hotness matters there); wb_sel only in WB.
    function automatic exp_t mk(string tag, logic [2:0] st, logic [11:0] af, logic [6:0] strb,
                                logic [5:0] sel, logic [5:0] selm, logic wb, logic ill);
        exp_t e;
        logic [11:0] afm;
        afm   = (st == 3'd3 || st == 3'd4) ? 12'h000 : 12'hFFF;
        e.tag = tag;
        e.val = {st, af, sel, strb, wb, ill};
        e.msk = {3'b111, afm, selm, 7'h7F, (st == 3'd4), 1'b1};
        return e;
    endfunction

    task automatic cyc(input logic r, input logic ack, input logic z, input exp_t e);
        exp_t        x;
        logic [29:0] obs;
        rstn     = r;
        mem_ack  = ack;
        alu_zero = z;
        sb.push_back(e);
        @(negedge clk);
        x   = sb.pop_front();
        obs = {state, alu_f, alu_a_sel, alu_b_sel, imm_sel,
               mem_req, mem_we, ir_we, pc_we, oldpc_we, aluout_we, rf_we, wb_sel, illegal};
        n_tests++;
        assert ((obs & x.msk) === (x.val & x.msk)) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (mask %h)", x.tag, obs & x.msk, x.val & x.msk, x.msk);
        end
        if (state != 3'd5) begin
            n_tests++;
            assert ($onehot(alu_f)) else begin
                n_fail++;
                $error("FAIL %s_onehot: observed alu_f %h expected one-hot", x.tag, alu_f);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [31:0] i, input string t);
        inst = i;
        cyc(1'b1, 1'b1, 1'b0, mk({t, "_if"}, 3'd0, 12'h001, MREQ | IRWE | PCWE | OPWE,
                                 6'b00_00_00, 6'b111100, 1'b0, 1'b0));
        cyc(1'b1, 1'b1, 1'b0, mk({t, "_id"}, 3'd1, 12'h001, AOWE,
                                 6'b10_10_10, 6'b111111, 1'b0, 1'b0));
    endtask

    initial begin
        rstn     = 1'b0;
        inst     = I_ADD;
        mem_ack  = 1'b1;
        alu_zero = 1'b0;

        // Reset held with mem_ack high: IF state, no strobes
        cyc(1'b0, 1'b1, 1'b0, mk("reset", 3'd0, 12'h001, NONE, 6'd0, 6'd0, 1'b0, 1'b0));
        cyc(1'b0, 1'b1, 1'b0, mk("reset2", 3'd0, 12'h001, NONE, 6'd0, 6'd0, 1'b0, 1'b0));

        // IF stall without ack after release
        cyc(1'b1, 1'b0, 1'b0, mk("if_wait", 3'd0, 12'h001, MREQ, 6'b00_00_00, 6'b111100, 1'b0, 1'b0));

        // add.w, ack every cycle: 0,1,2,4,0
        fetch_decode(I_ADD, "add");
        cyc(1'b1, 1'b1, 1'b0, mk("add_ex", 3'd2, 12'h001, AOWE, 6'b01_01_00, 6'b111100, 1'b0, 1'b0));
        cyc(1'b1, 1'b1, 1'b0, mk("add_wb", 3'd4, 12'h000, RFWE, 6'd0, 6'd0, 1'b0, 1'b0));

        // ld.w with three wait cycles in MEM
        fetch_decode(I_LD, "ld");
        cyc(1'b1, 1'b0, 1'b0, mk("ld_ex", 3'd2, 12'h001, AOWE, 6'b01_10_00, 6'b111111, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 1'b0, 1'b0, mk("ld_mem_wait", 3'd3, 12'h000, MREQ, 6'd0, 6'd0, 1'b0, 1'b0));
        cyc(1'b1, 1'b1, 1'b0, mk("ld_mem_ack", 3'd3, 12'h000, MREQ, 6'd0, 6'd0, 1'b0, 1'b0));
        cyc(1'b1, 1'b1, 1'b0, mk("ld_wb", 3'd4, 12'h000, RFWE, 6'd0, 6'd0, 1'b1, 1'b0));

        // beq taken / not taken, bne taken
        fetch_decode(I_BEQ, "beq_t");
        cyc(1'b1, 1'b1, 1'b1, mk("beq_t_ex", 3'd2, 12'h002, PCWE, 6'b01_01_00, 6'b111100, 1'b0, 1'b0));
        fetch_decode(I_BEQ, "beq_n");
        cyc(1'b1, 1'b1, 1'b0, mk("beq_n_ex", 3'd2, 12'h002, NONE, 6'b01_01_00, 6'b111100, 1'b0, 1'b0));
        fetch_decode(I_BNE, "bne_t");
        cyc(1'b1, 1'b1, 1'b0, mk("bne_t_ex", 3'd2, 12'h002, PCWE, 6'b01_01_00, 6'b111100, 1'b0, 1'b0));

        // lu12i.w
        fetch_decode(I_LU12I, "lu12i");
        cyc(1'b1, 1'b1, 1'b0, mk("lu12i_ex", 3'd2, 12'h800, AOWE, 6'b00_10_01, 6'b001111, 1'b0, 1'b0));
        cyc(1'b1, 1'b1, 1'b0, mk("lu12i_wb", 3'd4, 12'h000, RFWE, 6'd0, 6'd0, 1'b0, 1'b0));

        // sra.w
        fetch_decode(I_SRA, "sra");
        cyc(1'b1, 1'b1, 1'b0, mk("sra_ex", 3'd2, 12'h400, AOWE, 6'b01_01_00, 6'b111100, 1'b0, 1'b0));
        cyc(1'b1, 1'b1, 1'b0, mk("sra_wb", 3'd4, 12'h000, RFWE, 6'd0, 6'd0, 1'b0, 1'b0));

        // addi.w
        fetch_decode(I_ADDI, "addi");
        cyc(1'b1, 1'b1, 1'b0, mk("addi_ex", 3'd2, 12'h001, AOWE, 6'b01_10_00, 6'b111111, 1'b0, 1'b0));
        cyc(1'b1, 1'b1, 1'b0, mk("addi_wb", 3'd4, 12'h000, RFWE, 6'd0, 6'd0, 1'b0, 1'b0));

        // st.w, zero-wait: 4 cycles back to IF
        fetch_decode(I_ST, "st");
        cyc(1'b1, 1'b1, 1'b0, mk("st_ex", 3'd2, 12'h001, AOWE, 6'b01_10_00, 6'b111111, 1'b0, 1'b0));
        cyc(1'b1, 1'b1, 1'b0, mk("st_mem", 3'd3, 12'h000, MREQ | MWE, 6'd0, 6'd0, 1'b0, 1'b0));
        cyc(1'b1, 1'b0, 1'b0, mk("st_next_if", 3'd0, 12'h001, MREQ, 6'b00_00_00, 6'b111100, 1'b0, 1'b0));

        // st.w aborted by reset mid-wait in MEM
        fetch_decode(I_ST, "st2");
        cyc(1'b1, 1'b0, 1'b0, mk("st2_ex", 3'd2, 12'h001, AOWE, 6'b01_10_00, 6'b111111, 1'b0, 1'b0));
        cyc(1'b1, 1'b0, 1'b0, mk("st2_mem_wait", 3'd3, 12'h000, MREQ | MWE, 6'd0, 6'd0, 1'b0, 1'b0));
        cyc(1'b0, 1'b1, 1'b0, mk("st2_abort", 3'd0, 12'h001, NONE, 6'd0, 6'd0, 1'b0, 1'b0));
        cyc(1'b1, 1'b0, 1'b0, mk("st2_restart", 3'd0, 12'h001, MREQ, 6'b00_00_00, 6'b111100, 1'b0, 1'b0));

        // Illegal opcode -> sticky HALT, cleared only by reset
        fetch_decode(I_BAD, "bad");
        for (int k = 0; k < 10; k++)
            cyc(1'b1, 1'b1, 1'b1, mk("halt", 3'd5, 12'h000, NONE, 6'd0, 6'd0, 1'b0, 1'b1));
        cyc(1'b0, 1'b1, 1'b0, mk("halt_reset", 3'd0, 12'h001, NONE, 6'd0, 6'd0, 1'b0, 1'b0));
        inst = I_ADD;
        cyc(1'b1, 1'b1, 1'b0, mk("post_halt_if", 3'd0, 12'h001, MREQ | IRWE | PCWE | OPWE,
                                 6'b00_00_00, 6'b111100, 1'b0, 1'b0));
        cyc(1'b1, 1'b1, 1'b0, mk("post_halt_id", 3'd1, 12'h001, AOWE, 6'b10_10_10, 6'b111111, 1'b0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
